vx_mem_req_arbiter: RTL and testbench
=====================================

Name: vx_mem_req_arbiter

Overview:
- Shares one memory request/response port among NUM_REQS requesters, e.g. clusters or cache banks contending for one VX_MEM_PORTS lane at the top level.
- Round-robin arbitration; appends the winner index to the tag; routes responses back by that index.
- Registered one-entry output stage.
- Outstanding-read credit counter caps in-flight reads at MAX_PENDING.

Parameters:
- NUM_REQS, 4: number of requesters (>=1).
- ADDR_WIDTH, 26: line address width.
- DATA_WIDTH, 512: data width.
- TAG_IN_WIDTH, 8: requester tag width.
- MAX_PENDING, 16: max outstanding reads (>=1).
- LG_REQS (derived): NUM_REQS>1 ? CLOG2(NUM_REQS) : 0.
- TAG_OUT_WIDTH (derived): TAG_IN_WIDTH+LG_REQS.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_req_valid  in  NUM_REQS  per-requester request valid.
- in_req_rw  in  NUM_REQS  1 = write.
- in_req_byteen  in  NUM_REQS*DATA_WIDTH/8  byte enables.
- in_req_addr  in  NUM_REQS*ADDR_WIDTH  address.
- in_req_data  in  NUM_REQS*DATA_WIDTH  write data.
- in_req_tag  in  NUM_REQS*TAG_IN_WIDTH  tag.
- in_req_ready  out  NUM_REQS  accept.
- in_rsp_valid  out  NUM_REQS  response valid.
- in_rsp_data  out  DATA_WIDTH  response data, shared by all requesters.
- in_rsp_tag  out  TAG_IN_WIDTH  original tag, shared.
- in_rsp_ready  in  NUM_REQS  response accept.
- mem_req_valid/rw/byteen/addr/data  out  1/1/DATA_WIDTH/8/ADDR_WIDTH/DATA_WIDTH  memory request.
- mem_req_tag  out  TAG_OUT_WIDTH  tag; index in the LSBs.
- mem_req_ready  in  1.
- mem_rsp_valid  in  1.
- mem_rsp_data  in  DATA_WIDTH.
- mem_rsp_tag  in  TAG_OUT_WIDTH.
- mem_rsp_ready  out  1.
- busy  out  1  output buffer occupied or reads pending.

Behaviour:
- Reset asserted (async): output buffer invalid, mem_req_valid=0, RR pointer=0, pending=0. Hence in_req_ready=0 and busy=0 while reset is held.
- Eligibility: requester i is eligible if in_req_valid[i] && (in_req_rw[i] || pending < MAX_PENDING). Pending is the registered value; there is no same-cycle response bypass.
- can_load = !buf_valid || mem_req_ready.
- Grant: first eligible index at or after rr_ptr, wrapping modulo NUM_REQS. in_req_ready[g] = can_load; all other in_req_ready bits = 0.
- rr_ptr updates to g+1 (wrapping) only on an input fire.
- On input fire the buffer loads the payload with mem_req_tag = {in_tag, g[LG_REQS-1:0]}. The request appears on mem_req_* the next cycle (latency 1).
- Accept-and-drain in the same cycle sustains 1 request/cycle.
- Output stage: buffer holds all fields stable while mem_req_valid && !mem_req_ready. Fire clears the buffer unless it reloads in the same cycle.
- Credits: pending, width CLOG2(MAX_PENDING+1).
  - +1 on read input fire.
  - -1 on mem_rsp fire.
  - Both in the same cycle: unchanged.
  - Saturates at 0: a response arriving after mid-operation reset must not underflow.
  - Writes consume no credit; they have no response.
- Response routing: idx = mem_rsp_tag[LG_REQS-1:0].
  - in_rsp_valid[j] = mem_rsp_valid && idx==j.
  - in_rsp_tag = mem_rsp_tag[TAG_OUT_WIDTH-1:LG_REQS].
  - mem_rsp_ready = in_rsp_ready[idx].
  - Combinational, zero latency.
- idx >= NUM_REQS is illegal: simulation assertion; mem_rsp_ready=0.
- NUM_REQS==1: no index bits, grant is always 0, tag passes through, and the register stage plus credits still apply.
- busy = buf_valid || pending != 0 (registered inputs, combinational OR).

Decomposition:
- Shared package: request/response payload struct types parameterised by widths, and the LG_REQS/TAG_OUT_WIDTH derivation helper.
- One natural sub-module: vx_mem_rr_select.
  - Inputs: eligible mask, rr_ptr.
  - Outputs: grant index, grant_valid.
  - Purely combinational.
- The top owns the buffer, rr_ptr, credit counter and response demux.

Test Plan:
1. NUM_REQS=4, all four reads valid, mem_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; mem_req_tag LSBs 0,1,2,3; first mem_req_valid one cycle after the first fire.
2. mem_req_ready=0 for 5 cycles with buffered req addr 0x100 -> mem_req_* stable; all in_req_ready=0; on release, fire plus new load in the same cycle.
3. MAX_PENDING=2, requester 1 issues 3 reads, no responses -> third blocked (in_req_ready[1]=0) while a write from requester 2 still passes; one mem_rsp fire -> third read accepted the next cycle.
4. mem_rsp_tag = {8'h5A, 2'd3}, in_rsp_ready[3]=0 for 2 cycles -> only in_rsp_valid[3]=1, in_rsp_tag=0x5A, mem_rsp_ready=0 until in_rsp_ready[3]=1.
5. Same cycle: read input fire and mem_rsp fire with pending=1 -> pending stays 1.
6. Assert reset mid-stream with buffer valid and pending=3 -> mem_req_valid=0, busy=0 immediately; a later stray response leaves pending at 0.

Source files
------------

// File: rtl/vx_mem_req_arbiter_pkg.sv
// Shared width derivations for the memory request arbiter and its round-robin selector.
package vx_mem_req_arbiter_pkg;

  function automatic int unsigned calc_lg_reqs(input int unsigned num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 0;
  endfunction

  // Index buses keep at least one bit so single-requester builds stay well formed.
  function automatic int unsigned calc_idx_width(input int unsigned num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int unsigned calc_tag_out_width(input int unsigned tag_in_width,
                                                     input int unsigned num_reqs);
    return tag_in_width + calc_lg_reqs(num_reqs);
  endfunction

endpackage

// File: rtl/vx_mem_rr_select.sv
// Round-robin pick: first eligible requester at or after rr_ptr_i, wrapping modulo NUM_REQS.
module vx_mem_rr_select
  import vx_mem_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic [NUM_REQS-1:0]  eligible_i,
  input  logic [IDX_WIDTH-1:0] rr_ptr_i,
  output logic [IDX_WIDTH-1:0] grant_idx_o,
  output logic                 grant_valid_o
);

  localparam int unsigned SUM_WIDTH = IDX_WIDTH + 1;

  logic [SUM_WIDTH-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      cand = SUM_WIDTH'(rr_ptr_i) + SUM_WIDTH'(k);
      if (cand >= SUM_WIDTH'(NUM_REQS)) begin
        cand = cand - SUM_WIDTH'(NUM_REQS);
      end
      if (eligible_i[cand[IDX_WIDTH-1:0]]) begin
        grant_idx_o   = cand[IDX_WIDTH-1:0];
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_mem_req_arbiter.sv
// Shares one memory port among NUM_REQS requesters: round-robin grant, one-entry
// registered request stage, read credit limit and tag-indexed response demux.
module vx_mem_req_arbiter
  import vx_mem_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS     = 4,
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned TAG_IN_WIDTH = 8,
  parameter int unsigned MAX_PENDING  = 16,
  localparam int unsigned LG_REQS       = calc_lg_reqs(NUM_REQS),
  localparam int unsigned TAG_OUT_WIDTH = calc_tag_out_width(TAG_IN_WIDTH, NUM_REQS),
  localparam int unsigned BYTEEN_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              in_req_valid,
  input  logic [NUM_REQS-1:0]              in_req_rw,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0] in_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   in_req_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] in_req_tag,
  output logic [NUM_REQS-1:0]              in_req_ready,
  output logic [NUM_REQS-1:0]              in_rsp_valid,
  output logic [DATA_WIDTH-1:0]            in_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]          in_rsp_tag,
  input  logic [NUM_REQS-1:0]              in_rsp_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]          mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic                             busy
);

  localparam int unsigned IDX_WIDTH  = calc_idx_width(NUM_REQS);
  localparam int unsigned PEND_WIDTH = $clog2(MAX_PENDING + 1);

  typedef struct packed {
    logic                     rw;
    logic [BYTEEN_WIDTH-1:0]  byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } mem_req_t;

  mem_req_t                 req_q, req_d, req_sel;
  logic                     valid_q, valid_d;
  logic [IDX_WIDTH-1:0]     rr_q, rr_d;
  logic [PEND_WIDTH-1:0]    pend_q, pend_d;

  logic [NUM_REQS-1:0]      eligible;
  logic [IDX_WIDTH-1:0]     grant_idx;
  logic                     grant_valid;
  logic                     can_load;
  logic                     in_fire;
  logic                     rd_fire;
  logic                     rsp_fire;
  logic                     rsp_legal;
  logic [IDX_WIDTH-1:0]     rsp_idx;
  logic [TAG_IN_WIDTH-1:0]  sel_tag;
  logic [TAG_OUT_WIDTH-1:0] req_tag_sel;

  // Writes never wait on credits; reads need a free outstanding slot.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = in_req_valid[i] && (in_req_rw[i] || (pend_q < PEND_WIDTH'(MAX_PENDING)));
    end
  end

  vx_mem_rr_select #(
    .NUM_REQS  (NUM_REQS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_select (
    .eligible_i    (eligible),
    .rr_ptr_i      (rr_q),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign sel_tag = in_req_tag[grant_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH];

  if (LG_REQS > 0) begin : g_idx
    assign req_tag_sel = {sel_tag, grant_idx};
    assign rsp_idx     = mem_rsp_tag[IDX_WIDTH-1:0];
  end else begin : g_noidx
    assign req_tag_sel = sel_tag;
    assign rsp_idx     = '0;
  end

  always_comb begin
    req_sel        = '0;
    req_sel.rw     = in_req_rw[grant_idx];
    req_sel.byteen = in_req_byteen[grant_idx*BYTEEN_WIDTH +: BYTEEN_WIDTH];
    req_sel.addr   = in_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    req_sel.data   = in_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    req_sel.tag    = req_tag_sel;
  end

  // Holding reset low blocks acceptance even though the empty buffer could load.
  assign can_load     = !valid_q || mem_req_ready;
  assign in_fire      = reset && grant_valid && can_load;
  assign rd_fire      = in_fire && !in_req_rw[grant_idx];
  assign in_req_ready = in_fire ? (NUM_REQS'(1) << grant_idx) : '0;

  assign rsp_legal     = (32'(rsp_idx) < NUM_REQS);
  assign mem_rsp_ready = rsp_legal && in_rsp_ready[rsp_idx];
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  assign in_rsp_valid  = (mem_rsp_valid && rsp_legal) ? (NUM_REQS'(1) << rsp_idx) : '0;
  assign in_rsp_data   = mem_rsp_data;
  assign in_rsp_tag    = mem_rsp_tag[TAG_OUT_WIDTH-1:LG_REQS];

  assign mem_req_valid  = valid_q;
  assign mem_req_rw     = req_q.rw;
  assign mem_req_byteen = req_q.byteen;
  assign mem_req_addr   = req_q.addr;
  assign mem_req_data   = req_q.data;
  assign mem_req_tag    = req_q.tag;
  assign busy           = valid_q || (pend_q != '0);

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    rr_d    = rr_q;
    pend_d  = pend_q;
    if (in_fire) begin
      valid_d = 1'b1;
      req_d   = req_sel;
      rr_d    = ((32'(grant_idx) + 32'd1) >= NUM_REQS) ? '0 : (grant_idx + IDX_WIDTH'(1));
    end else if (mem_req_ready) begin
      valid_d = 1'b0;
    end
    // Simultaneous issue and return cancel; a stray return never wraps below zero.
    if (rd_fire && !rsp_fire) begin
      pend_d = pend_q + PEND_WIDTH'(1);
    end else if (!rd_fire && rsp_fire && (pend_q != '0)) begin
      pend_d = pend_q - PEND_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      req_q   <= '0;
      rr_q    <= '0;
      pend_q  <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
    end
  end

  a_rsp_idx_legal : assert property (@(posedge clk) disable iff (!reset)
    mem_rsp_valid |-> rsp_legal);

endmodule

// File: tb/tb_vx_mem_req_arbiter.sv
// Randomized bench for vx_mem_req_arbiter against a cycle-level reference model.
module tb_vx_mem_req_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 26;
  localparam int unsigned DW  = 32;
  localparam int unsigned TW  = 8;
  localparam int unsigned MP  = 4;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned TOW = TW + 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready;
  logic [N*BW-1:0] in_req_byteen;
  logic [N*AW-1:0] in_req_addr;
  logic [N*DW-1:0] in_req_data;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_rsp_valid, in_rsp_ready;
  logic [DW-1:0]   in_rsp_data;
  logic [TW-1:0]   in_rsp_tag;
  logic            mem_req_valid, mem_req_rw, mem_req_ready;
  logic [BW-1:0]   mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [TOW-1:0]  mem_req_tag;
  logic            mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0]   mem_rsp_data;
  logic [TOW-1:0]  mem_rsp_tag;
  logic            busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: pending read count, round-robin start, buffered request.
  bit             m_bv;
  int             m_rr, m_pend;
  logic           m_rw;
  logic [BW-1:0]  m_be;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_data;
  logic [TOW-1:0] m_tag;

  int             e_g;
  bit             e_fire, e_rsp_ready;
  logic [N-1:0]   e_in_ready, e_rsp_valid;

  always #5 clk = ~clk;

  vx_mem_req_arbiter #(
    .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
    .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    int ridx;
    e_g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (e_g < 0 && in_req_valid[j] && (in_req_rw[j] || m_pend < MP)) e_g = j;
    end
    e_fire      = (e_g >= 0) && (!m_bv || mem_req_ready);
    e_in_ready  = e_fire ? N'(1 << e_g) : '0;
    ridx        = int'(mem_rsp_tag) % N;
    e_rsp_ready = in_rsp_ready[ridx];
    e_rsp_valid = mem_rsp_valid ? N'(1 << ridx) : '0;
  endtask

  task automatic check_all();
    check("in_req_ready", 64'(in_req_ready), 64'(e_in_ready));
    check("in_rsp_valid", 64'(in_rsp_valid), 64'(e_rsp_valid));
    check("in_rsp_tag", 64'(in_rsp_tag), 64'(mem_rsp_tag >> 2));
    check("in_rsp_data", 64'(in_rsp_data), 64'(mem_rsp_data));
    check("mem_rsp_ready", 64'(mem_rsp_ready), 64'(e_rsp_ready));
    check("busy", 64'(busy), 64'(m_bv || m_pend != 0));
    check("mem_req_valid", 64'(mem_req_valid), 64'(m_bv));
    if (m_bv) begin
      check("mem_req_rw", 64'(mem_req_rw), 64'(m_rw));
      check("mem_req_byteen", 64'(mem_req_byteen), 64'(m_be));
      check("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
      check("mem_req_data", 64'(mem_req_data), 64'(m_data));
      check("mem_req_tag", 64'(mem_req_tag), 64'(m_tag));
    end
  endtask

  task automatic model_step();
    bit rsp_fire, rd;
    rsp_fire = mem_rsp_valid && e_rsp_ready;
    rd       = e_fire && !in_req_rw[e_g];
    if (e_fire) begin
      m_bv   = 1'b1;
      m_rw   = in_req_rw[e_g];
      m_be   = in_req_byteen[e_g*BW +: BW];
      m_addr = in_req_addr[e_g*AW +: AW];
      m_data = in_req_data[e_g*DW +: DW];
      m_tag  = {in_req_tag[e_g*TW +: TW], 2'(e_g)};
      m_rr   = (e_g + 1) % N;
    end else if (mem_req_ready) begin
      m_bv = 1'b0;
    end
    if (rd && !rsp_fire) m_pend++;
    else if (!rd && rsp_fire && m_pend > 0) m_pend--;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    in_req_valid = '0; in_req_rw = '0; in_req_byteen = '0; in_req_addr = '0;
    in_req_data = '0; in_req_tag = '0; in_rsp_ready = '0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
  endtask

  task automatic set_req(input int i, input bit rw, input logic [AW-1:0] addr);
    in_req_valid[i]         = 1'b1;
    in_req_rw[i]            = rw;
    in_req_addr[i*AW +: AW] = addr;
    in_req_data[i*DW +: DW] = DW'($urandom);
    in_req_byteen[i*BW +: BW] = BW'($urandom);
    in_req_tag[i*TW +: TW]  = TW'($urandom);
  endtask

  task automatic rand_inputs(input int vpct, input int rdy_pct, input int rsp_pct);
    for (int i = 0; i < N; i++) begin
      set_req(i, $urandom_range(99) < 30, AW'($urandom));
      in_req_valid[i] = $urandom_range(99) < vpct;
    end
    mem_req_ready = $urandom_range(99) < rdy_pct;
    mem_rsp_valid = $urandom_range(99) < rsp_pct;
    mem_rsp_tag   = TOW'($urandom);
    mem_rsp_data  = DW'($urandom);
    in_rsp_ready  = N'($urandom);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    in_req_valid = '1;
    reset = 1'b0;
    #1;
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_req_ready", 64'(in_req_ready), 64'd0);
    m_bv = 1'b0; m_rr = 0; m_pend = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    #1;
    do_reset();

    // All four requesters issue reads into an always-ready port.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(32'h40 + i));
    repeat (6) cycle();

    // Stall the output stage with a buffered write to 0x100.
    idle();
    in_rsp_ready = '1;
    mem_rsp_valid = 1'b1;
    repeat (5) cycle();
    idle();
    set_req(0, 1'b1, AW'(32'h100));
    cycle();
    mem_req_ready = 1'b0;
    set_req(1, 1'b1, AW'(32'h200));
    repeat (5) cycle();
    mem_req_ready = 1'b1;
    cycle();
    idle();
    cycle();

    // Response to requester 3 waits until that requester is ready.
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {8'h5A, 2'd3};
    mem_rsp_data  = DW'(32'hCAFE_F00D);
    in_rsp_ready  = 4'b0111;
    repeat (2) begin
      @(negedge clk);
      check("t4_rsp_valid", 64'(in_rsp_valid), 64'h8);
      check("t4_rsp_tag", 64'(in_rsp_tag), 64'h5A);
      check("t4_rsp_ready", 64'(mem_rsp_ready), 64'd0);
      @(posedge clk);
      model_eval();
      model_step();
      #1;
    end
    in_rsp_ready = 4'b1000;
    cycle();
    idle();

    for (int p = 0; p < 4; p++) begin
      repeat (500) begin
        case (p)
          0: rand_inputs(60, 80, 30);
          1: rand_inputs(90, 50, 10);
          2: rand_inputs(40, 95, 60);
          default: rand_inputs(100, 30, 20);
        endcase
        cycle();
      end
    end

    // Mid-stream reset with a buffered request and three reads outstanding.
    idle();
    do_reset();
    set_req(0, 1'b0, AW'(32'h10));
    cycle();
    idle();
    set_req(1, 1'b0, AW'(32'h11));
    cycle();
    idle();
    set_req(2, 1'b0, AW'(32'h12));
    cycle();
    idle();
    mem_req_ready = 1'b0;
    cycle();
    do_reset();
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {8'h33, 2'd1};
    in_rsp_ready  = '1;
    repeat (2) cycle();
    idle();
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
